// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter with a small valid/ready input FIFO.
//            Queued bytes are sent as back-to-back frames with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          send,
    output logic                          ready,
    output logic                          serial,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int c_cnt_w = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLOCKS_PER_BIT - 1);
    localparam logic [c_aw:0]      c_full = (c_aw + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_clk_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_serial;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_aw:0]        r_count;

    state_t               w_next_state;
    logic [c_cnt_w-1:0]   w_next_clk_cnt;
    logic [2:0]           w_next_bit_cnt;
    logic [7:0]           w_next_shift;
    logic                 w_next_serial;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_fifo_has_data;

    // Push is suppressed while full and while reset is held.
    assign ready           = (r_count != c_full);
    assign w_push          = send && ready && !reset;
    assign w_fifo_has_data = (r_count != '0);
    assign w_bit_end       = (r_clk_cnt == c_last);
    assign pending         = r_count;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_STOP) && w_bit_end;
    assign serial          = r_serial;

    // Next-state, counter, shift and line-level logic for the framing FSM.
    always_comb begin
        w_next_state   = r_state;
        w_next_clk_cnt = r_clk_cnt + c_cnt_w'(1);
        w_next_bit_cnt = r_bit_cnt;
        w_next_shift   = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_clk_cnt = '0;
                if (w_fifo_has_data) begin
                    w_pop        = 1'b1;
                    w_next_shift = r_mem[r_rd_ptr];
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_clk_cnt = '0;
                    w_next_bit_cnt = '0;
                    w_next_state   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_next_clk_cnt = '0;
                    w_next_shift   = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state = S_STOP;
                    end else begin
                        w_next_bit_cnt = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                if (w_bit_end) begin
                    w_next_clk_cnt = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (w_fifo_has_data) begin
                        w_pop        = 1'b1;
                        w_next_shift = r_mem[r_rd_ptr];
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
        endcase
        // The line register is loaded with the level of the state being entered,
        // so serial changes exactly on bit boundaries.
        case (w_next_state)
            S_START: w_next_serial = 1'b0;
            S_DATA:  w_next_serial = w_next_shift[0];
            default: w_next_serial = 1'b1;
        endcase
    end

    // FSM state, counters, shift register and registered line output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_clk_cnt <= w_next_clk_cnt;
            r_bit_cnt <= w_next_bit_cnt;
            r_shift   <= w_next_shift;
            r_serial  <= w_next_serial;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Scoreboard bench for uart_tx. Stimulus queues expected bytes; an
//            independent monitor decodes every frame on the line and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_cpb  = 4;
    localparam int c_cpb2 = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       send;
    logic       ready, serial, busy, done;
    logic [2:0] pending;

    logic [7:0] data2;
    logic       send2;
    logic       ready2, serial2, busy2, done2;
    logic [2:0] pending2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_q [$];
    int         done_t [$];

    uart_tx #(.CLOCKS_PER_BIT(c_cpb), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .data(data), .send(send), .ready(ready),
        .serial(serial), .busy(busy), .done(done), .pending(pending)
    );

    uart_tx #(.CLOCKS_PER_BIT(c_cpb2), .FIFO_DEPTH(4)) dut2 (
        .clock(clock), .reset(reset), .data(data2), .send(send2), .ready(ready2),
        .serial(serial2), .busy(busy2), .done(done2), .pending(pending2)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one byte for one edge; checks ready/pending as seen just before it.
    task automatic push(input logic [7:0] b, input logic exp_ready, input logic [2:0] exp_pend);
        @(negedge clock);
        chk("push_ready", ready, exp_ready);
        chk("push_pending", pending, exp_pend);
        data = b;
        send = 1'b1;
        if (exp_ready) exp_q.push_back(b);
    endtask

    task automatic release_send();
        @(negedge clock);
        send = 1'b0;
        data = 8'hEE;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", seen, 1'b1);
    endtask

    // Frame monitor: decodes the line independently of stimulus timing.
    initial begin
        logic       in_frame;
        logic [9:0] frm;
        int         bi, cy;
        in_frame = 1'b0;
        frm = '0; bi = 0; cy = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (serial === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_frame: start bit seen with empty scoreboard (cycle %0d)", cyc);
                        end else begin
                            frm = {1'b1, exp_q.pop_front(), 1'b0};
                            in_frame = 1'b1;
                            bi = 0;
                            cy = 0;
                        end
                    end else begin
                        chk("idle_busy", busy, 1'b0);
                        chk("idle_done", done, 1'b0);
                    end
                end
                if (in_frame) begin
                    chk("frame_bit", serial, frm[bi]);
                    chk("frame_busy", busy, 1'b1);
                    chk("frame_done", done, (bi == 9 && cy == c_cpb - 1));
                    if (done === 1'b1) done_t.push_back(cyc);
                    cy++;
                    if (cy == c_cpb) begin
                        cy = 0;
                        bi++;
                        if (bi == 10) in_frame = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        send  = 1'b1;          // ignored while reset is held
        data  = 8'h77;
        send2 = 1'b0;
        data2 = 8'h00;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_serial", serial, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pending", pending, 3'd0);
        send = 1'b0;
        #1 reset = 1'b0;

        // Idle for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("idle_serial", serial, 1'b1);
            chk("idle_ready", ready, 1'b1);
            chk("idle_pending", pending, 3'd0);
        end

        // Single byte 0xA5.
        push(8'hA5, 1'b1, 3'd0);
        release_send();
        wait_done(60);
        repeat (3) @(negedge clock);
        chk("single_busy_after", busy, 1'b0);

        // Back-to-back 0x00, 0xFF, 0x3C.
        done_t.delete();
        push(8'h00, 1'b1, 3'd0);
        push(8'hFF, 1'b1, 3'd1);
        push(8'h3C, 1'b1, 3'd1);
        release_send();
        chk("b2b_pending_max", pending, 3'd2);
        wait_done(60);
        @(negedge clock);
        chk("b2b_pending_f2", pending, 3'd1);
        wait_done(60);
        @(negedge clock);
        chk("b2b_pending_f3", pending, 3'd0);
        wait_done(60);
        chk("b2b_done_count", done_t.size(), 3);
        if (done_t.size() >= 3) begin
            chk("b2b_spacing_1", done_t[1] - done_t[0], 40);
            chk("b2b_spacing_2", done_t[2] - done_t[1], 40);
        end
        repeat (3) @(negedge clock);

        // Full FIFO: six pushes, the sixth is refused.
        push(8'h11, 1'b1, 3'd0);
        push(8'h22, 1'b1, 3'd1);
        push(8'h33, 1'b1, 3'd1);
        push(8'h44, 1'b1, 3'd2);
        push(8'h55, 1'b1, 3'd3);
        push(8'h66, 1'b0, 3'd4);
        release_send();
        chk("full_ready", ready, 1'b0);
        chk("full_pending", pending, 3'd4);
        wait_done(60);
        @(negedge clock);
        chk("full_ready_back", ready, 1'b1);
        chk("full_pending_after_pop", pending, 3'd3);
        for (int i = 0; i < 4; i++) wait_done(60);
        repeat (5) @(negedge clock);
        chk("full_busy_after", busy, 1'b0);
        chk("full_sb_empty", exp_q.size(), 0);

        // Reset in the third data bit of 0x55 with another byte queued.
        push(8'h55, 1'b1, 3'd0);
        push(8'h12, 1'b1, 3'd1);
        release_send();
        chk("rstmid_pending", pending, 3'd1);
        repeat (13) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_serial", serial, 1'b1);
        chk("rstmid_pending0", pending, 3'd0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_ready", ready, 1'b1);
        exp_q.delete();
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rstmid_idle_serial", serial, 1'b1);
        push(8'h81, 1'b1, 3'd0);
        release_send();
        wait_done(60);
        repeat (3) @(negedge clock);
        chk("rstmid_sb_empty", exp_q.size(), 0);

        // Two clocks per bit: 0xFF gives a 2-cycle start bit then 18 high cycles.
        @(negedge clock);
        data2 = 8'hFF;
        send2 = 1'b1;
        @(negedge clock);
        send2 = 1'b0;
        data2 = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            chk("cpb2_serial", serial2, (i <= 2) ? 1'b0 : 1'b1);
            chk("cpb2_done", done2, (i == 20));
        end
        @(negedge clock);
        chk("cpb2_busy_after", busy2, 1'b0);
        chk("cpb2_pending", pending2, 3'd0);

        chk("final_sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
